// File: rtl/reg_file_rename_if.sv
// Decoder/ROB-facing bundle of the rename register file.
//   master : drives rename, source indices and commit/roll back (decoder + ROB side)
//   slave  : the register file; returns source operand state
interface reg_file_rename_if #(
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ROB_ID_WIDTH  = 4
);
  // decoder rename / read
  logic                     ID_rename_valid;
  logic [REG_IDX_WIDTH-1:0] ID_rd;
  logic [ROB_ID_WIDTH-1:0]  ID_ROB_id;
  logic [REG_IDX_WIDTH-1:0] ID_rs1;
  logic [REG_IDX_WIDTH-1:0] ID_rs2;
  logic                     ID_rs1_busy;
  logic [ROB_ID_WIDTH-1:0]  ID_rs1_ROB_id;
  logic [DATA_WIDTH-1:0]    ID_rs1_value;
  logic                     ID_rs2_busy;
  logic [ROB_ID_WIDTH-1:0]  ID_rs2_ROB_id;
  logic [DATA_WIDTH-1:0]    ID_rs2_value;
  // ROB commit / flush
  logic                     ROB_commit_valid;
  logic [REG_IDX_WIDTH-1:0] ROB_commit_rd;
  logic [ROB_ID_WIDTH-1:0]  ROB_commit_ROB_id;
  logic [DATA_WIDTH-1:0]    ROB_commit_value;
  logic                     ROB_roll_back_flag;

  modport master (
    output ID_rename_valid, ID_rd, ID_ROB_id, ID_rs1, ID_rs2,
    output ROB_commit_valid, ROB_commit_rd, ROB_commit_ROB_id, ROB_commit_value,
    output ROB_roll_back_flag,
    input  ID_rs1_busy, ID_rs1_ROB_id, ID_rs1_value,
    input  ID_rs2_busy, ID_rs2_ROB_id, ID_rs2_value
  );

  modport slave (
    input  ID_rename_valid, ID_rd, ID_ROB_id, ID_rs1, ID_rs2,
    input  ROB_commit_valid, ROB_commit_rd, ROB_commit_ROB_id, ROB_commit_value,
    input  ROB_roll_back_flag,
    output ID_rs1_busy, ID_rs1_ROB_id, ID_rs1_value,
    output ID_rs2_busy, ID_rs2_ROB_id, ID_rs2_value
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Ports:
//   clk  - clock, all updates on rising edge
//   rst  - synchronous active-low reset
//   rdy  - global ready; state holds while low
//   bus  - slave side of reg_file_rename_if (decoder rename/read, ROB commit/roll back)
// Reads are combinational, with a same-cycle bypass from a matching commit.
module reg_file_rename #(
  parameter int unsigned REG_NUM      = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ROB_ID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  reg_file_rename_if.slave      bus
);

  logic [DATA_WIDTH-1:0]   value_q [REG_NUM];
  logic                    busy_q  [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] tag_q   [REG_NUM];

  logic do_commit;
  logic do_rename;

  assign do_commit = bus.ROB_commit_valid && (bus.ROB_commit_rd != '0);
  assign do_rename = bus.ID_rename_valid && (bus.ID_rd != '0) && !bus.ROB_roll_back_flag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (do_commit) begin
        value_q[bus.ROB_commit_rd] <= bus.ROB_commit_value;
        if (tag_q[bus.ROB_commit_rd] == bus.ROB_commit_ROB_id)
          busy_q[bus.ROB_commit_rd] <= 1'b0;
      end
      if (bus.ROB_roll_back_flag) begin
        for (int unsigned i = 0; i < REG_NUM; i++)
          busy_q[i] <= 1'b0;
      end
      // Issued last so a same-cycle rename of the committing rd keeps it busy.
      if (do_rename) begin
        busy_q[bus.ID_rd] <= 1'b1;
        tag_q[bus.ID_rd]  <= bus.ID_ROB_id;
      end
    end
  end

  always_comb begin
    bus.ID_rs1_busy   = 1'b0;
    bus.ID_rs1_ROB_id = '0;
    bus.ID_rs1_value  = '0;
    if (bus.ID_rs1 != '0) begin
      bus.ID_rs1_busy   = busy_q[bus.ID_rs1];
      bus.ID_rs1_ROB_id = tag_q[bus.ID_rs1];
      bus.ID_rs1_value  = value_q[bus.ID_rs1];
      if (bus.ROB_commit_valid && bus.ROB_commit_rd == bus.ID_rs1 && busy_q[bus.ID_rs1]
          && tag_q[bus.ID_rs1] == bus.ROB_commit_ROB_id) begin
        bus.ID_rs1_busy  = 1'b0;
        bus.ID_rs1_value = bus.ROB_commit_value;
      end
    end
  end

  always_comb begin
    bus.ID_rs2_busy   = 1'b0;
    bus.ID_rs2_ROB_id = '0;
    bus.ID_rs2_value  = '0;
    if (bus.ID_rs2 != '0) begin
      bus.ID_rs2_busy   = busy_q[bus.ID_rs2];
      bus.ID_rs2_ROB_id = tag_q[bus.ID_rs2];
      bus.ID_rs2_value  = value_q[bus.ID_rs2];
      if (bus.ROB_commit_valid && bus.ROB_commit_rd == bus.ID_rs2 && busy_q[bus.ID_rs2]
          && tag_q[bus.ID_rs2] == bus.ROB_commit_ROB_id) begin
        bus.ID_rs2_busy  = 1'b0;
        bus.ID_rs2_value = bus.ROB_commit_value;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename.
module tb_reg_file_rename;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  reg_file_rename_if #(.REG_IDX_WIDTH(5), .DATA_WIDTH(32), .ROB_ID_WIDTH(4)) bus ();

  reg_file_rename #(.REG_NUM(32), .DATA_WIDTH(32), .ROB_ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ID_rename_valid    = 1'b0;
    bus.ID_rd              = '0;
    bus.ID_ROB_id          = '0;
    bus.ROB_commit_valid   = 1'b0;
    bus.ROB_commit_rd      = '0;
    bus.ROB_commit_ROB_id  = '0;
    bus.ROB_commit_value   = '0;
    bus.ROB_roll_back_flag = 1'b0;
  endtask

  // advance one edge; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] id);
    bus.ID_rename_valid = 1'b1;
    bus.ID_rd           = rd;
    bus.ID_ROB_id       = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
    bus.ROB_commit_valid  = 1'b1;
    bus.ROB_commit_rd     = rd;
    bus.ROB_commit_ROB_id = id;
    bus.ROB_commit_value  = v;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    idle();
    bus.ID_rs1 = '0;
    bus.ID_rs2 = '0;
    tick();
    tick();
    rst = 1'b1;

    // reset state
    bus.ID_rs1 = 5'd5; settle();
    check("rst_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("rst_value", bus.ID_rs1_value, 32'd0);
    check("rst_id", 32'(bus.ID_rs1_ROB_id), 32'd0);

    // commit with tag mismatch still writes value
    commit(5'd5, 4'd3, 32'h1234); tick(); idle(); settle();
    check("x5_value", bus.ID_rs1_value, 32'h1234);
    check("x5_busy", 32'(bus.ID_rs1_busy), 32'd0);

    // rename then read busy/tag, then bypass from commit
    rename(5'd7, 4'd2); tick(); idle();
    bus.ID_rs1 = 5'd7; settle();
    check("x7_busy", 32'(bus.ID_rs1_busy), 32'd1);
    check("x7_id", 32'(bus.ID_rs1_ROB_id), 32'd2);
    commit(5'd7, 4'd2, 32'hABCD); settle();
    check("bypass_value", bus.ID_rs1_value, 32'hABCD);
    check("bypass_busy", 32'(bus.ID_rs1_busy), 32'd0);
    tick(); idle(); settle();
    check("x7_committed_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("x7_committed_value", bus.ID_rs1_value, 32'hABCD);

    // newer rename keeps busy on older commit
    rename(5'd7, 4'd2); tick(); idle();
    rename(5'd7, 4'd9); tick(); idle();
    commit(5'd7, 4'd2, 32'd5); tick(); idle();
    bus.ID_rs2 = 5'd7; settle();
    check("stale_value", bus.ID_rs2_value, 32'd5);
    check("stale_busy", 32'(bus.ID_rs2_busy), 32'd1);
    check("stale_id", 32'(bus.ID_rs2_ROB_id), 32'd9);
    commit(5'd7, 4'd9, 32'd6); tick(); idle(); settle();
    check("newer_busy", 32'(bus.ID_rs2_busy), 32'd0);
    check("newer_value", bus.ID_rs2_value, 32'd6);

    // same-cycle rename and matching commit on x4
    rename(5'd4, 4'd6); tick(); idle();
    rename(5'd4, 4'd6); commit(5'd4, 4'd6, 32'h77);
    bus.ID_rs1 = 5'd4; settle();
    check("x4_pre_id", 32'(bus.ID_rs1_ROB_id), 32'd6);
    check("x4_pre_value", bus.ID_rs1_value, 32'h77);
    check("x4_pre_busy", 32'(bus.ID_rs1_busy), 32'd0);
    tick(); idle(); settle();
    check("x4_value", bus.ID_rs1_value, 32'h77);
    check("x4_busy", 32'(bus.ID_rs1_busy), 32'd1);
    check("x4_id", 32'(bus.ID_rs1_ROB_id), 32'd6);

    // roll back with simultaneous rename and commit
    rename(5'd3, 4'd1); tick(); idle();
    rename(5'd8, 4'd4); tick(); idle();
    rename(5'd9, 4'd5); tick(); idle();
    bus.ROB_roll_back_flag = 1'b1;
    rename(5'd10, 4'd7);
    commit(5'd8, 4'd4, 32'h55);
    tick(); idle();
    bus.ID_rs1 = 5'd3; bus.ID_rs2 = 5'd8; settle();
    check("rb_x3_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("rb_x8_busy", 32'(bus.ID_rs2_busy), 32'd0);
    check("rb_x8_value", bus.ID_rs2_value, 32'h55);
    bus.ID_rs1 = 5'd9; bus.ID_rs2 = 5'd10; settle();
    check("rb_x9_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("rb_x9_tag_kept", 32'(bus.ID_rs1_ROB_id), 32'd5);
    check("rb_x10_busy", 32'(bus.ID_rs2_busy), 32'd0);
    check("rb_x10_tag", 32'(bus.ID_rs2_ROB_id), 32'd0);

    // x0 is never renamed or written, even through the bypass
    rename(5'd0, 4'd3); commit(5'd0, 4'd3, 32'hFFFF);
    bus.ID_rs1 = 5'd0; settle();
    check("x0_bypass_value", bus.ID_rs1_value, 32'd0);
    tick(); idle(); settle();
    check("x0_value", bus.ID_rs1_value, 32'd0);
    check("x0_busy", 32'(bus.ID_rs1_busy), 32'd0);

    // rdy low holds state
    rdy = 1'b0;
    rename(5'd2, 4'd5); commit(5'd5, 4'd3, 32'h99);
    tick(); idle(); rdy = 1'b1;
    bus.ID_rs1 = 5'd2; bus.ID_rs2 = 5'd5; settle();
    check("rdy_x2_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("rdy_x5_value", bus.ID_rs2_value, 32'h1234);

    // reset mid-stream, with a pending rename that must be discarded
    rename(5'd6, 4'd3); tick(); idle();
    rst = 1'b0; rename(5'd11, 4'd2); commit(5'd5, 4'd0, 32'h4242);
    tick(); idle(); rst = 1'b1;
    bus.ID_rs1 = 5'd6; bus.ID_rs2 = 5'd5; settle();
    check("rst2_x6_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("rst2_x6_id", 32'(bus.ID_rs1_ROB_id), 32'd0);
    check("rst2_x5_value", bus.ID_rs2_value, 32'd0);
    bus.ID_rs1 = 5'd11; bus.ID_rs2 = 5'd4; settle();
    check("rst2_x11_busy", 32'(bus.ID_rs1_busy), 32'd0);
    check("rst2_x4_value", bus.ID_rs2_value, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags; the commit-side consumer of the reorder buffer.
- Decoder reads source operands here: either the committed value, or the ROB id that will produce it.
- Decoder renames the destination register on every issued instruction.
- ROB commits retire values into the file; ROB roll back discards all outstanding renames.

Parameters:
REG_NUM, 32, number of architectural registers (index width 5)
DATA_WIDTH, 32, register value width
ROB_ID_WIDTH, 4, width of a rename tag (ROB depth 16)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low: state clears on the clk edge where rst==0
rdy  input  1  global ready; when 0 all state holds
ID_rename_valid  input  1  decoder issues an instruction that writes a register
ID_rd  input  5  destination register of issued instruction
ID_ROB_id  input  ROB_ID_WIDTH  ROB entry allocated to that instruction
ID_rs1  input  5  source register 1 index
ID_rs2  input  5  source register 2 index
ID_rs1_busy  output  1  rs1 awaits an in-flight producer
ID_rs1_ROB_id  output  ROB_ID_WIDTH  producer tag for rs1 (valid when busy)
ID_rs1_value  output  DATA_WIDTH  rs1 value (valid when not busy)
ID_rs2_busy  output  1  as rs1
ID_rs2_ROB_id  output  ROB_ID_WIDTH  as rs1
ID_rs2_value  output  DATA_WIDTH  as rs1
ROB_commit_valid  input  1  ROB retires a register-writing instruction this cycle
ROB_commit_rd  input  5  retiring destination register
ROB_commit_ROB_id  input  ROB_ID_WIDTH  ROB entry being retired
ROB_commit_value  input  DATA_WIDTH  retiring result
ROB_roll_back_flag  input  1  mispredict flush, one-cycle pulse

Behaviour:
- State: value[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (rst==0 at edge): all value=0, busy=0, tag=0. Read outputs are combinational, so they read 0/0/0 after reset. Reset mid-operation discards all pending renames and commits that cycle.
- rdy==0: no state change. Read outputs remain combinational from the held state.
- Read ports, combinational, per rsN:
  - rsN==0: value=0, busy=0, ROB_id=0.
  - Commit bypass: if ROB_commit_valid && ROB_commit_rd==rsN && busy[rsN] && tag[rsN]==ROB_commit_ROB_id, then value=ROB_commit_value, busy=0.
  - Otherwise value/busy/ROB_id come from stored state.
  - A same-cycle rename is never visible on reads. An instruction with rs==rd sees the old mapping.
- Commit (edge, rdy=1, ROB_commit_valid=1, rd!=0):
  - value[rd] <= ROB_commit_value, always.
  - busy[rd] <= 0 only if tag[rd]==ROB_commit_ROB_id and no same-cycle rename of rd. A newer rename keeps busy.
- Rename (edge, rdy=1, ID_rename_valid=1, ID_rd!=0, no roll back): busy[rd] <= 1, tag[rd] <= ID_ROB_id.
- Priority on the same rd in one cycle: rename sets busy/tag, commit still writes value. Rename to x0 is ignored.
- Roll back (edge, rdy=1, ROB_roll_back_flag=1):
  - All busy <= 0; tags unchanged.
  - A rename the same cycle is dropped.
  - A commit the same cycle still writes its value.
- x0 value is never written. Commit to rd 0 is ignored.
- Latency: rename and commit become visible on reads the cycle after the edge. Commit is also visible the same cycle through the bypass.
- Tag wrap: tags are plain ROB indices (0..15); no age comparison, equality only.

Test Plan:
- Reset then read x5 -> busy=0, value=0. Commit rd=5, id=3, value=0x1234 with tag mismatch -> next cycle x5 value=0x1234, busy=0.
- Rename rd=7, id=2; next cycle read rs1=7 -> busy=1, ROB_id=2. Commit rd=7, id=2, value=0xABCD same cycle as read -> bypass value=0xABCD, busy=0; next cycle stored busy=0.
- Rename rd=7 id=2, then rename rd=7 id=9, then commit rd=7 id=2 value=5 -> value[7]=5 but busy=1, tag=9. Commit id=9 value=6 -> busy=0, value=6.
- Same-cycle rename rd=4 id=6 and commit rd=4 (tag matches, value=0x77) -> value=0x77, busy=1, tag=6. Read rs1=4 that cycle shows pre-edge state.
- Rename x3,x8,x9, then roll back pulse with simultaneous rename x10 and commit x8 value=0x55 -> all busy=0, x10 not busy, x8=0x55.
- Rename/commit to x0 value=0xFFFF -> reads 0, busy 0. rdy=0 with rename x2 -> x2 not busy. rst=0 mid-stream -> all zero next cycle.
